// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash arbiter and its handshake tracker.
package spi_flash_pkg;

  localparam int CMD_W   = 8;
  localparam int CTYP_W  = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NBITS_W = 7;
  localparam int DUMMY_W = 4;
  localparam int FRAME_W = 10;
  localparam int MODE_W  = 2;
  localparam int XIPB_W  = 2;

  localparam logic [CMD_W-1:0]  CMD_WREN      = 8'h06;
  localparam logic [CMD_W-1:0]  CMD_RDSR      = 8'h05;
  localparam logic [CTYP_W-1:0] CTYP_CMD_ONLY = 3'd0;
  localparam logic [CTYP_W-1:0] CTYP_RDSR     = 3'd1;

  typedef enum logic [2:0] {ST_IDLE, ST_WREN, ST_MAIN, ST_POLL, ST_RESP} arb_state_t;
  typedef enum logic [1:0] {HS_IDLE, HS_ISSUE, HS_ACK, HS_BUSY} hs_state_t;

  typedef struct packed {
    logic [CMD_W-1:0]   command;
    logic [CTYP_W-1:0]  commtype;
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  data_in;
    logic [NBITS_W-1:0] ndata_bits;
    logic [DUMMY_W-1:0] dummy_cycles;
    logic [FRAME_W-1:0] frame_struct;
    logic [MODE_W-1:0]  spimode;
    logic               dtr_en;
    logic               fourbyte;
  } xfer_req_t;

  // Builds a request with only the listed fields set; everything else is zero.
  function automatic xfer_req_t make_req(input logic [CMD_W-1:0] cmd,
                                         input logic [CTYP_W-1:0] ctyp,
                                         input logic [NBITS_W-1:0] nbits,
                                         input logic [DUMMY_W-1:0] dummy,
                                         input logic [ADDR_W-1:0] addr);
    xfer_req_t r;
    r              = '0;
    r.command      = cmd;
    r.commtype     = ctyp;
    r.ndata_bits   = nbits;
    r.dummy_cycles = dummy;
    r.address      = addr;
    return r;
  endfunction

endpackage

// File: rtl/spi_xfer_hs.sv
// ISSUE/ACK/BUSY tracker for one master transfer. done is combinational so the
// next transfer (start in the same cycle) can raise m_validflag one cycle later.
module spi_xfer_hs
  import spi_flash_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              m_tready,
  input  logic [DATA_W-1:0] m_data_out,
  output logic              m_validflag,
  output logic              done,
  output logic [DATA_W-1:0] xfer_data
);

  hs_state_t st;

  assign done      = (st == HS_BUSY) && m_tready;
  assign xfer_data = done ? m_data_out : '0;

  // Transfer handshake sequencing; a start on the done cycle chains straight into ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= HS_IDLE;
      m_validflag <= 1'b0;
    end else begin
      case (st)
        HS_IDLE: if (start) begin
          st          <= HS_ISSUE;
          m_validflag <= 1'b1;
        end
        HS_ISSUE: if (m_validflag && m_tready) begin
          st          <= HS_ACK;
          m_validflag <= 1'b0;
        end
        HS_ACK: if (!m_tready) st <= HS_BUSY;
        HS_BUSY: if (m_tready) begin
          st          <= start ? HS_ISSUE : HS_IDLE;
          m_validflag <= start;
        end
        default: st <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_flash_arb.sv
// Round-robin CPU/XIP arbiter and transfer sequencer for the SPI flash master.
// Build option: SPI_FLASH_AUTOWEL_EN adds the WREN / status-poll wrapper for CPU requests.
module spi_flash_arb
  import spi_flash_pkg::*;
#(
  parameter logic [7:0]  XIP_CMD   = 8'h0B,
  parameter logic [2:0]  XIP_CTYP  = 3'b001,
  parameter logic [3:0]  XIP_DUMMY = 4'd8,
  parameter logic [15:0] POLL_MAX  = 16'hFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_valid,
  output logic         cpu_ready,
  input  logic [7:0]   cpu_command,
  input  logic [2:0]   cpu_commtype,
  input  logic [31:0]  cpu_address,
  input  logic [31:0]  cpu_data_in,
  input  logic [6:0]   cpu_ndata_bits,
  input  logic [3:0]   cpu_dummy_cycles,
  input  logic [9:0]   cpu_frame_struct,
  input  logic [1:0]   cpu_spimode,
  input  logic         cpu_dtr_en,
  input  logic         cpu_4byteaddr,
  input  logic         cpu_wel_en,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_rvalid,
  output logic         cpu_err,
  input  logic         xip_valid,
  input  logic [31:0]  xip_address,
  output logic         xip_ready,
  output logic [31:0]  xip_rdata,
  output logic         xip_rvalid,
  output logic         m_validflag,
  input  logic         m_tready,
  input  logic [31:0]  m_data_out,
  output logic [7:0]   m_command,
  output logic [2:0]   m_commtype,
  output logic [31:0]  m_address,
  output logic [31:0]  m_data_in,
  output logic [6:0]   m_ndata_bits,
  output logic [3:0]   m_dummy_cycles,
  output logic [9:0]   m_frame_struct,
  output logic [1:0]   m_spimode,
  output logic         m_dtr_en,
  output logic         m_fourbyteaddr_on,
  output logic [XIPB_W-1:0] m_xipbit_en
);

  arb_state_t  state;
  xfer_req_t   m_req, cpu_req, xip_req;
  logic        prio_cpu, own_xip, go_r;
  logic        grant_cpu, grant_xip;
  logic        hs_start, hs_done, chain_go;
  logic [31:0] hs_data;

  assign cpu_req = {cpu_command, cpu_commtype, cpu_address, cpu_data_in, cpu_ndata_bits,
                    cpu_dummy_cycles, cpu_frame_struct, cpu_spimode, cpu_dtr_en, cpu_4byteaddr};
  assign xip_req = make_req(XIP_CMD, XIP_CTYP, 7'd32, XIP_DUMMY, xip_address);

  // prio_cpu is the round-robin pointer: set after an XIP grant (and out of reset).
  assign grant_cpu = (state == ST_IDLE) && cpu_valid && (!xip_valid || prio_cpu);
  assign grant_xip = (state == ST_IDLE) && xip_valid && !grant_cpu;

  assign m_command         = m_req.command;
  assign m_commtype        = m_req.commtype;
  assign m_address         = m_req.address;
  assign m_data_in         = m_req.data_in;
  assign m_ndata_bits      = m_req.ndata_bits;
  assign m_dummy_cycles    = m_req.dummy_cycles;
  assign m_frame_struct    = m_req.frame_struct;
  assign m_spimode         = m_req.spimode;
  assign m_dtr_en          = m_req.dtr_en;
  assign m_fourbyteaddr_on = m_req.fourbyte;
  assign m_xipbit_en       = '0;

`ifdef SPI_FLASH_AUTOWEL_EN
  logic        wel_q, err_q;
  logic [15:0] poll_cnt;
  xfer_req_t   saved_req;
  logic [31:0] rsp_data;

  assign cpu_err = err_q;

  // Transfers that follow directly on a done without passing through IDLE.
  always_comb begin
    chain_go = 1'b0;
    if (hs_done) begin
      case (state)
        ST_WREN: chain_go = 1'b1;
        ST_MAIN: chain_go = wel_q;
        ST_POLL: chain_go = hs_data[0] && (poll_cnt != POLL_MAX);
        default: chain_go = 1'b0;
      endcase
    end
  end
`else
  logic [16:0] unused_cfg;
  assign unused_cfg = {cpu_wel_en, POLL_MAX};
  assign cpu_err    = 1'b0;
  assign chain_go   = 1'b0;
`endif

  assign hs_start = go_r | chain_go;

  spi_xfer_hs u_hs (
    .clk         (clk),
    .rst         (rst),
    .start       (hs_start),
    .m_tready    (m_tready),
    .m_data_out  (m_data_out),
    .m_validflag (m_validflag),
    .done        (hs_done),
    .xfer_data   (hs_data)
  );

  // Sequencer: arbitration in IDLE, request field loading and response pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      prio_cpu   <= 1'b1;
      own_xip    <= 1'b0;
      go_r       <= 1'b0;
      m_req      <= '0;
      cpu_ready  <= 1'b0;
      xip_ready  <= 1'b0;
      cpu_rvalid <= 1'b0;
      xip_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      xip_rdata  <= '0;
`ifdef SPI_FLASH_AUTOWEL_EN
      wel_q      <= 1'b0;
      err_q      <= 1'b0;
      poll_cnt   <= '0;
      saved_req  <= '0;
      rsp_data   <= '0;
`endif
    end else begin
      cpu_ready  <= 1'b0;
      xip_ready  <= 1'b0;
      cpu_rvalid <= 1'b0;
      xip_rvalid <= 1'b0;
      go_r       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_cpu) begin
            cpu_ready <= 1'b1;
            go_r      <= 1'b1;
            prio_cpu  <= 1'b0;
            own_xip   <= 1'b0;
`ifdef SPI_FLASH_AUTOWEL_EN
            err_q     <= 1'b0;
            poll_cnt  <= '0;
            wel_q     <= cpu_wel_en;
            saved_req <= cpu_req;
            if (cpu_wel_en) begin
              m_req <= make_req(CMD_WREN, CTYP_CMD_ONLY, '0, '0, '0);
              state <= ST_WREN;
            end else begin
              m_req <= cpu_req;
              state <= ST_MAIN;
            end
`else
            m_req     <= cpu_req;
            state     <= ST_MAIN;
`endif
          end else if (grant_xip) begin
            xip_ready <= 1'b1;
            go_r      <= 1'b1;
            prio_cpu  <= 1'b1;
            own_xip   <= 1'b1;
            m_req     <= xip_req;
            state     <= ST_MAIN;
`ifdef SPI_FLASH_AUTOWEL_EN
            wel_q     <= 1'b0;
`endif
          end
        end
`ifdef SPI_FLASH_AUTOWEL_EN
        ST_WREN: if (hs_done) begin
          m_req <= saved_req;
          state <= ST_MAIN;
        end
        ST_POLL: if (hs_done) begin
          if (!hs_data[0] || poll_cnt == POLL_MAX) begin
            err_q      <= hs_data[0];
            state      <= ST_RESP;
            cpu_rvalid <= 1'b1;
            cpu_rdata  <= rsp_data;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
          end
        end
`endif
        ST_MAIN: if (hs_done) begin
`ifdef SPI_FLASH_AUTOWEL_EN
          rsp_data <= hs_data;
          if (wel_q) begin
            m_req <= make_req(CMD_RDSR, CTYP_RDSR, 7'd8, '0, '0);
            state <= ST_POLL;
          end else
`endif
          begin
            state <= ST_RESP;
            if (own_xip) begin
              xip_rvalid <= 1'b1;
              xip_rdata  <= hs_data;
            end else begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= hs_data;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arb.sv
// Self-checking bench for spi_flash_arb with a reactive master model and a response scoreboard.
module tb_spi_flash_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_valid = 1'b0, cpu_ready;
  logic [7:0]  cpu_command = '0;
  logic [2:0]  cpu_commtype = '0;
  logic [31:0] cpu_address = '0, cpu_data_in = '0;
  logic [6:0]  cpu_ndata_bits = '0;
  logic [3:0]  cpu_dummy_cycles = '0;
  logic [9:0]  cpu_frame_struct = '0;
  logic [1:0]  cpu_spimode = '0;
  logic        cpu_dtr_en = 1'b0, cpu_4byteaddr = 1'b0, cpu_wel_en = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid, cpu_err;
  logic        xip_valid = 1'b0;
  logic [31:0] xip_address = '0;
  logic        xip_ready, xip_rvalid;
  logic [31:0] xip_rdata;
  logic        m_validflag;
  logic        m_tready = 1'b1;
  logic [31:0] m_data_out = '0;
  logic [7:0]  m_command;
  logic [2:0]  m_commtype;
  logic [31:0] m_address, m_data_in;
  logic [6:0]  m_ndata_bits;
  logic [3:0]  m_dummy_cycles;
  logic [9:0]  m_frame_struct;
  logic [1:0]  m_spimode;
  logic        m_dtr_en, m_fourbyteaddr_on;
  logic [1:0]  m_xipbit_en;

  int checks = 0;
  int errors = 0;

  typedef struct { logic xip; logic [31:0] data; logic err; } exp_t;
  typedef struct { logic [7:0] cmd; logic [2:0] ctyp; logic [31:0] addr; logic [31:0] din;
                   logic [6:0] nb; logic [3:0] dum; } xfer_t;
  exp_t        exp_q[$];
  xfer_t       xlog[$];
  logic [31:0] rsp_q[$];

  spi_flash_arb #(.XIP_CMD(8'h0B), .XIP_CTYP(3'b001), .XIP_DUMMY(4'd8), .POLL_MAX(16'd3)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_command(cpu_command),
    .cpu_commtype(cpu_commtype), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_ndata_bits(cpu_ndata_bits), .cpu_dummy_cycles(cpu_dummy_cycles),
    .cpu_frame_struct(cpu_frame_struct), .cpu_spimode(cpu_spimode), .cpu_dtr_en(cpu_dtr_en),
    .cpu_4byteaddr(cpu_4byteaddr), .cpu_wel_en(cpu_wel_en), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
    .xip_valid(xip_valid), .xip_address(xip_address), .xip_ready(xip_ready),
    .xip_rdata(xip_rdata), .xip_rvalid(xip_rvalid),
    .m_validflag(m_validflag), .m_tready(m_tready), .m_data_out(m_data_out),
    .m_command(m_command), .m_commtype(m_commtype), .m_address(m_address),
    .m_data_in(m_data_in), .m_ndata_bits(m_ndata_bits), .m_dummy_cycles(m_dummy_cycles),
    .m_frame_struct(m_frame_struct), .m_spimode(m_spimode), .m_dtr_en(m_dtr_en),
    .m_fourbyteaddr_on(m_fourbyteaddr_on), .m_xipbit_en(m_xipbit_en)
  );

  always #5 clk = ~clk;

  // Master model: acts on falling edges, logs each accepted request, answers from rsp_q.
  int          mstate = 0;
  int          mcnt = 0;
  logic [31:0] mval = '0;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mstate = 0;
      m_tready = 1'b1;
      m_data_out = '0;
    end else begin
      case (mstate)
        0: if (m_validflag && m_tready) begin
          xlog.push_back('{m_command, m_commtype, m_address, m_data_in, m_ndata_bits, m_dummy_cycles});
          mval = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
          mstate = 1;
        end
        1: begin
          m_tready = 1'b0;
          mcnt = 2;
          mstate = 2;
        end
        default: begin
          mcnt--;
          if (mcnt == 0) begin
            m_tready = 1'b1;
            m_data_out = mval;
            mstate = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drive_cpu(input logic [7:0] cmd, input logic [31:0] addr, input logic wel);
    cpu_command = cmd;
    cpu_commtype = 3'd2;
    cpu_address = addr;
    cpu_data_in = 32'h0;
    cpu_ndata_bits = 7'd32;
    cpu_wel_en = wel;
    cpu_valid = 1'b1;
  endtask

  task automatic wait_ready(output bit gc, output bit gx, output int n);
    gc = 0;
    gx = 0;
    for (n = 0; n < 100; n++) begin
      tick();
      if (cpu_ready || xip_ready) begin
        gc = cpu_ready;
        gx = xip_ready;
        break;
      end
    end
  endtask

  task automatic wait_resp(output bit got, output exp_t obs, output bit rise_ok);
    logic prev;
    prev = m_tready;
    got = 0;
    rise_ok = 0;
    obs = '{1'b0, 32'h0, 1'b0};
    for (int n = 0; n < 400; n++) begin
      tick();
      if (cpu_rvalid || xip_rvalid) begin
        got = 1;
        obs = '{xip_rvalid, xip_rvalid ? xip_rdata : cpu_rdata, cpu_err};
        rise_ok = !prev && m_tready;
        break;
      end
      prev = m_tready;
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({cpu_ready, cpu_rdata, cpu_rvalid, cpu_err, xip_ready, xip_rdata, xip_rvalid, m_validflag,
         m_command, m_commtype, m_address, m_data_in, m_ndata_bits, m_dummy_cycles,
         m_frame_struct, m_spimode, m_dtr_en, m_fourbyteaddr_on, m_xipbit_en} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero during reset (cmd=%h vld=%b) required all 0",
               m_command, m_validflag);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    bit gc, gx, got, rise;
    int n;
    exp_t e, o;
    xlog.delete();
    rsp_q.push_back(32'hDEADBEEF);
    exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    drive_cpu(8'h03, 32'h0000_1000, 1'b0);
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    checks++;
    if (!(gc && !gx)) begin errors++; $display("FAIL cpu_accept: cpu_ready=%b xip_ready=%b required 1 0", gc, gx); end
    checks++;
    if (m_validflag !== 1'b0) begin errors++; $display("FAIL cpu_vld_n: m_validflag=%b required 0", m_validflag); end
    tick();
    checks++;
    if (m_validflag !== 1'b1 || m_command !== 8'h03) begin
      errors++; $display("FAIL cpu_vld_n1: m_validflag=%b cmd=%h required 1 03", m_validflag, m_command);
    end
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++; $display("FAIL cpu_read_resp: got=%b xip=%b data=%h err=%b required 1 %b %h %b", got, o.xip, o.data, o.err, e.xip, e.data, e.err);
    end
    checks++;
    if (!rise) begin errors++; $display("FAIL cpu_resp_latency: rvalid not one cycle after tready rise, required 1 cycle"); end
    tick();
    checks++;
    if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rvalid_pulse: cpu_rvalid=%b required 0", cpu_rvalid); end
    checks++;
    if (xlog.size() != 1 || xlog[0].cmd !== 8'h03) begin
      errors++; $display("FAIL cpu_xfer_count: transfers=%0d required 1 (cmd 03)", xlog.size());
    end
  endtask

  task automatic test_xip();
    bit gc, gx, got, rise;
    int n;
    exp_t e, o;
    xlog.delete();
    rsp_q.push_back(32'h1234_5678);
    exp_q.push_back('{1'b1, 32'h1234_5678, 1'b0});
    xip_address = 32'h0010_0000;
    xip_valid = 1'b1;
    wait_ready(gc, gx, n);
    xip_valid = 1'b0;
    checks++;
    if (!(gx && !gc)) begin errors++; $display("FAIL xip_accept: cpu_ready=%b xip_ready=%b required 0 1", gc, gx); end
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin
      errors++; $display("FAIL xip_resp: got=%b xip=%b data=%h required 1 %b %h", got, o.xip, o.data, e.xip, e.data);
    end
    tick();
    checks++;
    if (xip_rvalid !== 1'b0) begin errors++; $display("FAIL xip_rvalid_pulse: xip_rvalid=%b required 0", xip_rvalid); end
    checks++;
    if (xlog.size() != 1 ||
        {xlog[0].cmd, xlog[0].ctyp, xlog[0].addr, xlog[0].din, xlog[0].nb, xlog[0].dum} !==
        {8'h0B, 3'b001, 32'h0010_0000, 32'h0, 7'd32, 4'd8}) begin
      errors++; $display("FAIL xip_fields: n=%0d cmd=%h ctyp=%0d addr=%h nb=%0d dum=%0d required 1 0b 1 00100000 32 8",
                         xlog.size(), xlog[0].cmd, xlog[0].ctyp, xlog[0].addr, xlog[0].nb, xlog[0].dum);
    end
  endtask

  task automatic test_arbitration();
    bit gc, gx, got, rise;
    int n;
    exp_t e, o;
    do_reset();
    rsp_q.push_back(32'hA1A1_0001);
    rsp_q.push_back(32'hB2B2_0002);
    rsp_q.push_back(32'hC3C3_0003);
    exp_q.push_back('{1'b0, 32'hA1A1_0001, 1'b0});
    exp_q.push_back('{1'b1, 32'hB2B2_0002, 1'b0});
    exp_q.push_back('{1'b0, 32'hC3C3_0003, 1'b0});
    drive_cpu(8'h03, 32'h100, 1'b0);
    xip_address = 32'h200;
    xip_valid = 1'b1;
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    checks++;
    if (!(gc && !gx)) begin errors++; $display("FAIL arb_first: cpu_ready=%b xip_ready=%b required 1 0", gc, gx); end
    for (int k = 0; k < 3; k++) begin
      wait_resp(got, o, rise);
      e = exp_q.pop_front();
      checks++;
      if (!got || o !== e) begin
        errors++; $display("FAIL arb_resp%0d: got=%b xip=%b data=%h required 1 %b %h", k, got, o.xip, o.data, e.xip, e.data);
      end
      if (k == 0) begin
        cpu_valid = 1'b1;
        wait_ready(gc, gx, n);
        xip_valid = 1'b0;
        checks++;
        if (!(gx && !gc)) begin errors++; $display("FAIL arb_alternate: cpu_ready=%b xip_ready=%b required 0 1", gc, gx); end
      end else if (k == 1) begin
        wait_ready(gc, gx, n);
        cpu_valid = 1'b0;
        checks++;
        if (!(gc && !gx)) begin errors++; $display("FAIL arb_cpu_alone: cpu_ready=%b xip_ready=%b required 1 0", gc, gx); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit gc, gx, got, rise;
    int n;
    exp_t e, o;
    rsp_q.push_back(32'h0000_0011);
    rsp_q.push_back(32'h0000_0022);
    exp_q.push_back('{1'b0, 32'h0000_0011, 1'b0});
    exp_q.push_back('{1'b0, 32'h0000_0022, 1'b0});
    drive_cpu(8'h03, 32'h300, 1'b0);
    wait_ready(gc, gx, n);
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL b2b_resp0: got=%b data=%h required 1 %h", got, o.data, e.data); end
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    checks++;
    if (!gc || n != 1) begin errors++; $display("FAIL b2b_gap: ready=%b cycles_after_resp=%0d required 1 2", gc, n + 1); end
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL b2b_resp1: got=%b data=%h required 1 %h", got, o.data, e.data); end
  endtask

`ifdef SPI_FLASH_AUTOWEL_EN
  task automatic test_autowel();
    bit gc, gx, got, rise;
    int n, nrdsr;
    exp_t e, o;
    logic [39:0] seq;
    xlog.delete();
    rsp_q = '{32'h0, 32'h0000_5A5A, 32'h1, 32'h1, 32'h0};
    exp_q.push_back('{1'b0, 32'h0000_5A5A, 1'b0});
    drive_cpu(8'h02, 32'h400, 1'b1);
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL wel_resp: got=%b data=%h err=%b required 1 %h %b", got, o.data, o.err, e.data, e.err); end
    seq = '0;
    foreach (xlog[i]) seq = {seq[31:0], xlog[i].cmd};
    checks++;
    if (xlog.size() != 5 || seq !== 40'h06_02_05_05_05) begin
      errors++; $display("FAIL wel_order: n=%0d seq=%h required 5 0602050505", xlog.size(), seq);
    end
    tick();
    xlog.delete();
    rsp_q = '{32'h0, 32'h0BAD_0000, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
    exp_q.push_back('{1'b0, 32'h0BAD_0000, 1'b1});
    drive_cpu(8'h20, 32'h500, 1'b1);
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL timeout_resp: got=%b data=%h err=%b required 1 %h %b", got, o.data, o.err, e.data, e.err); end
    nrdsr = 0;
    foreach (xlog[i]) if (xlog[i].cmd == 8'h05) nrdsr++;
    checks++;
    if (nrdsr != 4 || xlog.size() != 6) begin errors++; $display("FAIL timeout_polls: rdsr=%0d total=%0d required 4 6", nrdsr, xlog.size()); end
    repeat (3) tick();
    checks++;
    if (cpu_err !== 1'b1) begin errors++; $display("FAIL err_sticky: cpu_err=%b required 1", cpu_err); end
    rsp_q.delete();
    rsp_q.push_back(32'h77);
    exp_q.push_back('{1'b0, 32'h77, 1'b0});
    drive_cpu(8'h03, 32'h600, 1'b0);
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    checks++;
    if (!gc || cpu_err !== 1'b0) begin errors++; $display("FAIL err_clear: ready=%b cpu_err=%b required 1 0", gc, cpu_err); end
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL after_err_resp: got=%b data=%h required 1 %h", got, o.data, e.data); end
  endtask
`else
  task automatic test_wel_ignored();
    bit gc, gx, got, rise;
    int n;
    exp_t e, o;
    xlog.delete();
    rsp_q.push_back(32'h0000_0009);
    exp_q.push_back('{1'b0, 32'h0000_0009, 1'b0});
    drive_cpu(8'h02, 32'h400, 1'b1);
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL wel_off_resp: got=%b data=%h err=%b required 1 %h 0", got, o.data, o.err, e.data); end
    checks++;
    if (xlog.size() != 1 || xlog[0].cmd !== 8'h02) begin
      errors++; $display("FAIL wel_off_xfers: n=%0d required 1 (cmd 02)", xlog.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit gc, gx, got, rise, seen;
    int n;
    exp_t e, o;
    rsp_q.delete();
    rsp_q.push_back(32'hFFFF_0000);
    drive_cpu(8'h03, 32'h700, 1'b0);
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (m_validflag !== 1'b0) begin errors++; $display("FAIL mid_in_ack: m_validflag=%b required 0", m_validflag); end
    rst = 1'b0;
    tick();
    checks++;
    if ({cpu_ready, cpu_rvalid, cpu_err, xip_ready, xip_rvalid, m_validflag, m_command, m_address, m_ndata_bits} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: vld=%b cmd=%h addr=%h required all 0", m_validflag, m_command, m_address);
    end
    tick();
    rst = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (cpu_rvalid || xip_rvalid) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_no_resp: rvalid seen=%b required 0", seen); end
    rsp_q.delete();
    rsp_q.push_back(32'h600D_F00D);
    exp_q.push_back('{1'b0, 32'h600D_F00D, 1'b0});
    drive_cpu(8'h03, 32'h800, 1'b0);
    wait_ready(gc, gx, n);
    cpu_valid = 1'b0;
    wait_resp(got, o, rise);
    e = exp_q.pop_front();
    checks++;
    if (!got || o !== e) begin errors++; $display("FAIL post_reset_resp: got=%b data=%h required 1 %h", got, o.data, e.data); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_xip();
    test_arbitration();
    test_back_to_back();
`ifdef SPI_FLASH_AUTOWEL_EN
    test_autowel();
`else
    test_wel_ignored();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
